// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter shared by instruction fetch and data access
//
// Purpose: grants one access at a time to a single-port memory, data before
// fetch, drives a req/ack memory handshake, reports done/stall per requester
// and raises a sticky error on protocol faults or an ack timeout.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_halt               blocks new fetch grants; an in-flight fetch completes
//   i_if_req/i_if_addr   fetch request (held until o_if_done) and address
//   o_if_done            one-cycle fetch completion pulse
//   o_if_data            last fetched word
//   o_if_stall           i_if_req & ~o_if_done
//   i_dm_rd/i_dm_wr      data read / write request (held until o_dm_done)
//   i_dm_addr/i_dm_wdata data address and write data
//   o_dm_done            one-cycle data completion pulse
//   o_dm_rdata           last data read word
//   o_dm_stall           (i_dm_rd | i_dm_wr) & ~o_dm_done
//   o_mem_req/o_mem_wr   memory request (held until ack) and write qualifier
//   o_mem_addr/o_mem_wdata memory address and write data
//   i_mem_ack/i_mem_rdata  one-cycle memory completion, read data same cycle
//   o_err                sticky error flag, cleared only by reset
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_halt,
   input  logic        i_if_req,
   input  logic [15:0] i_if_addr,
   output logic        o_if_done,
   output logic [15:0] o_if_data,
   output logic        o_if_stall,
   input  logic        i_dm_rd,
   input  logic        i_dm_wr,
   input  logic [15:0] i_dm_addr,
   input  logic [15:0] i_dm_wdata,
   output logic        o_dm_done,
   output logic [15:0] o_dm_rdata,
   output logic        o_dm_stall,
   output logic        o_mem_req,
   output logic        o_mem_wr,
   output logic [15:0] o_mem_addr,
   output logic [15:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [15:0] i_mem_rdata,
   output logic        o_err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DM_BUSY = 2'd1,
      S_IF_BUSY = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // The counter value that, incremented once more, reaches TIMEOUT.
   localparam logic [7:0] L_CNT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic        r_wr;
   logic        r_dm_sel;     // 1: current/last access serves the data port
   logic        r_err;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_if_data;
   logic [15:0] r_dm_rdata;

   logic        w_dm_any;
   logic        w_busy;
   logic        w_grant_dm;
   logic        w_grant_if;
   logic        w_timeout;

   assign w_dm_any   = i_dm_rd | i_dm_wr;
   assign w_busy     = (r_state == S_DM_BUSY) || (r_state == S_IF_BUSY);
   assign w_grant_dm = (r_state == S_IDLE) && w_dm_any;
   assign w_grant_if = (r_state == S_IDLE) && !w_dm_any && i_if_req && !i_halt;
   // An ack on the same edge the counter would reach TIMEOUT wins.
   assign w_timeout  = w_busy && !i_mem_ack && (r_cnt == L_CNT_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_dm_any)                  w_next = S_DM_BUSY;
            else if (i_if_req && !i_halt)  w_next = S_IF_BUSY;
         end
         S_DM_BUSY, S_IF_BUSY: begin
            if (i_mem_ack || w_timeout)    w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= 8'd0;
         r_wr       <= 1'b0;
         r_dm_sel   <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= 16'h0000;
         r_wdata    <= 16'h0000;
         r_if_data  <= 16'h0000;
         r_dm_rdata <= 16'h0000;
      end else if (w_grant_dm) begin
         r_cnt    <= 8'd0;
         r_addr   <= i_dm_addr;
         r_wdata  <= i_dm_wdata;
         // Simultaneous rd and wr is flagged and served as a read.
         r_wr     <= i_dm_wr & ~i_dm_rd;
         r_dm_sel <= 1'b1;
         if ((i_dm_rd & i_dm_wr) | i_dm_addr[0]) r_err <= 1'b1;
      end else if (w_grant_if) begin
         r_cnt    <= 8'd0;
         r_addr   <= i_if_addr;
         r_wr     <= 1'b0;
         r_dm_sel <= 1'b0;
         if (i_if_addr[0]) r_err <= 1'b1;
      end else if (w_busy) begin
         if (i_mem_ack) begin
            if (!r_dm_sel)  r_if_data  <= i_mem_rdata;
            else if (!r_wr) r_dm_rdata <= i_mem_rdata;
         end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout) begin
               r_err <= 1'b1;
               if (!r_dm_sel)  r_if_data  <= 16'h0000;
               else if (!r_wr) r_dm_rdata <= 16'h0000;
            end
         end
      end
   end

   assign o_mem_req   = w_busy;
   assign o_mem_wr    = r_wr;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_if_done   = (r_state == S_DONE) && !r_dm_sel;
   assign o_dm_done   = (r_state == S_DONE) && r_dm_sel;
   assign o_if_data   = r_if_data;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_if_stall  = i_if_req & ~o_if_done;
   assign o_dm_stall  = w_dm_any & ~o_dm_done;
   assign o_err       = r_err;

endmodule
